// File: rtl/mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux4_arbiter
// Purpose  : Round-robin arbiter driving a 4:1 mux select, with bounded hold
//            time per grant and a mandatory idle bubble between grants.
// Revision : 1.0  initial release
// ============================================================================
module mux4_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic       busy
);

    localparam logic [7:0] C_MAX_HOLD = 8'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    logic [3:0] r_gnt;
    logic [1:0] r_sel;
    logic       r_busy;
    logic [1:0] r_ptr;
    logic [7:0] r_hold;

    logic [6:0] w_dbl;
    logic [3:0] w_rot;
    logic [1:0] w_off;
    logic [1:0] w_pick;
    logic       w_found;
    logic       w_release;

    // Rotate req so bit k is requester (ptr+k) mod 4; lowest set bit wins.
    assign w_dbl   = {req[2:0], req};
    assign w_rot   = w_dbl[r_ptr +: 4];
    assign w_found = |req;
    assign w_pick  = r_ptr + w_off;

    always_comb begin
        w_off = 2'd0;
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    assign w_release = !req[r_sel] || (r_hold == C_MAX_HOLD);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_busy  <= 1'b0;
            r_ptr   <= 2'd0;
            r_hold  <= 8'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state <= ST_GRANT;
                        r_gnt   <= 4'b0001 << w_pick;
                        r_sel   <= w_pick;
                        r_busy  <= 1'b1;
                        r_hold  <= 8'd1;
                    end
                end
                ST_GRANT: begin
                    // Select is left at the last owner while idle.
                    if (w_release) begin
                        r_state <= ST_IDLE;
                        r_gnt   <= 4'b0000;
                        r_busy  <= 1'b0;
                        r_ptr   <= r_sel + 2'd1;
                        r_hold  <= 8'd0;
                    end else begin
                        r_hold  <= r_hold + 8'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt  = r_gnt;
    assign s0   = r_sel[0];
    assign s1   = r_sel[1];
    assign busy = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mux4_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux4_arbiter
// Purpose  : Directed vector bench for mux4_arbiter (MAX_HOLD=8 and 1).
// Revision : 1.0  initial release
// ============================================================================
module tb_mux4_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst8, rst1;
    logic [3:0] req8, req1;
    logic [3:0] gnt8, gnt1;
    logic       s0_8, s1_8, busy8;
    logic       s0_1, s1_1, busy1;

    int total = 0;
    int bad   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    mux4_arbiter #(.MAX_HOLD(8)) dut8 (
        .clk(clk), .rst(rst8), .req(req8), .gnt(gnt8),
        .s0(s0_8), .s1(s1_8), .busy(busy8)
    );

    mux4_arbiter #(.MAX_HOLD(1)) dut1 (
        .clk(clk), .rst(rst1), .req(req1), .gnt(gnt1),
        .s0(s0_1), .s1(s1_1), .busy(busy1)
    );

    function automatic void add(input logic r, input logic [3:0] rq,
                                input logic [3:0] g, input logic [1:0] s,
                                input logic b, input int n);
        vec_t v;
        v.rst = r; v.req = rq; v.gnt = g; v.sel = s; v.busy = b;
        for (int k = 0; k < n; k++) tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step%0d got=%b want=%b", name, idx, act, exp);
        end
    endtask

    initial begin
        rst8 = 1'b1; req8 = 4'b0000;
        rst1 = 1'b1; req1 = 4'b0000;

        // reset and idle
        add(1, 4'b0000, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 2);
        // single requester 2 held: 8-cycle grant, bubble, re-grant
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 8);
        add(0, 4'b0100, 4'b0000, 2'd2, 0, 1);
        add(0, 4'b0100, 4'b0100, 2'd2, 1, 1);
        add(0, 4'b0000, 4'b0000, 2'd2, 0, 1);
        // owner 1 drops after 3 cycles while req[3] waits
        add(0, 4'b0010, 4'b0010, 2'd1, 1, 1);
        add(0, 4'b1010, 4'b0010, 2'd1, 1, 2);
        add(0, 4'b1000, 4'b0000, 2'd1, 0, 1);
        add(0, 4'b1000, 4'b1000, 2'd3, 1, 1);
        add(0, 4'b0000, 4'b0000, 2'd3, 0, 1);
        // grant to 0, non-owner bits toggle, hold limit releases
        add(0, 4'b0001, 4'b0001, 2'd0, 1, 1);
        for (int k = 0; k < 7; k++)
            add(0, (k % 2 == 0) ? 4'b0111 : 4'b0001, 4'b0001, 2'd0, 1, 1);
        add(0, 4'b0111, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b0111, 4'b0010, 2'd1, 1, 1);
        add(0, 4'b0000, 4'b0000, 2'd1, 0, 1);
        // reset mid-grant to 3, then req 1001 from ptr=0
        add(0, 4'b1000, 4'b1000, 2'd3, 1, 2);
        add(1, 4'b1000, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1001, 4'b0001, 2'd0, 1, 1);
        add(0, 4'b0000, 4'b0000, 2'd0, 0, 1);
        // all requesting: full rotation
        add(1, 4'b0000, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 8);
        add(0, 4'b1111, 4'b0000, 2'd0, 0, 1);
        add(0, 4'b1111, 4'b0010, 2'd1, 1, 8);
        add(0, 4'b1111, 4'b0000, 2'd1, 0, 1);
        add(0, 4'b1111, 4'b0100, 2'd2, 1, 8);
        add(0, 4'b1111, 4'b0000, 2'd2, 0, 1);
        add(0, 4'b1111, 4'b1000, 2'd3, 1, 8);
        add(0, 4'b1111, 4'b0000, 2'd3, 0, 1);
        add(0, 4'b1111, 4'b0001, 2'd0, 1, 1);

        for (int i = 0; i < tbl.size(); i++) begin
            rst8 = tbl[i].rst;
            req8 = tbl[i].req;
            @(posedge clk);
            #1;
            chk("gnt",  i, gnt8, tbl[i].gnt);
            chk("sel",  i, {2'b00, s1_8, s0_8}, {2'b00, tbl[i].sel});
            chk("busy", i, {3'b000, busy8}, {3'b000, tbl[i].busy});
        end

        // MAX_HOLD=1: one-cycle grants separated by one idle cycle
        chk("mh1_rst_gnt", 0, gnt1, 4'b0000);
        rst1 = 1'b0;
        req1 = 4'b0011;
        for (int i = 0; i < 10; i++) begin
            logic [3:0] eg;
            @(posedge clk);
            #1;
            eg = (i % 2 == 1) ? 4'b0000 : ((i % 4 == 0) ? 4'b0001 : 4'b0010);
            chk("mh1_gnt",  i, gnt1, eg);
            chk("mh1_busy", i, {3'b000, busy1}, {3'b000, |eg});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
